// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared types and default timing constants for the stopwatch front end and counter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: key_state_t (key FSM encoding), default cycle counts at CLK_HZ, counter-width helper.
package stopwatch_pkg;

  // Default timing, all expressed in CLOCK_50 cycles.
  localparam int CLK_HZ       = 50_000_000;
  localparam int DEBOUNCE_CYC = 1_000_000;    // 20 ms
  localparam int LONG_CYC     = 100_000_000;  // 2 s
  localparam int TICK_CYC     = 50_000_000;   // 1 Hz

  // Key handling FSM. Encodings are fixed so the state can be probed on a logic analyser.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DEB_PRESS = 3'd1,
    HELD      = 3'd2,
    LONG      = 3'd3,
    DEB_REL   = 3'd4
  } key_state_t;

  // Width of a counter that must reach n-1; never narrower than one bit so
  // degenerate parameter values (n = 1) still yield a legal vector.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stopwatch_key_ctrl_tick_div.sv
// tick_div: divides CLOCK_50 down to a one-cycle tick every TICK_CYC enabled cycles.
// Latency: first tick TICK_CYC cycles after en rises; tick is registered.
// Backpressure: none; the tick is a free-running strobe while en is held.
// Ports: CLOCK_50 clock; KEY0 sync active-low reset; en count enable (low clears
//        the partial count); restart forces the count back to 0 with no tick; tick output strobe.
module tick_div
  import stopwatch_pkg::*;
#(
  parameter int TICK_CYC = stopwatch_pkg::TICK_CYC
) (
  input  logic CLOCK_50,
  input  logic KEY0,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int TW = cnt_w(TICK_CYC);
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_CYC - 1);

  logic [TW-1:0] cnt;

  // The count only ever climbs to TICK_MAX and is then returned to 0 in the
  // same cycle the tick is issued, so it can never wrap.
  always_ff @(posedge CLOCK_50) begin
    if (!KEY0) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (restart || !en) begin
      // Dropping en (pause) or a restart discards any partial period and
      // swallows a tick that would have been due in this cycle.
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == TICK_MAX) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/stopwatch_key_ctrl.sv
// stopwatch_key_ctrl: conditions KEY1, classifies short/long presses, drives run and the gated tick.
// Latency: 2-cycle synchronizer, DEBOUNCE_CYC press/release debounce; all outputs registered.
// Backpressure: none; tick/clear/key_pulse are one-cycle strobes the counter must take unconditionally.
// Ports: CLOCK_50 clock; KEY0 synchronous active-low reset; KEY1 raw active-low bouncy key;
//        run level (1 = counting); tick, clear, key_pulse one-cycle strobes, mutually exclusive.
// Build option: STOPWATCH_AUTOSTART_EN -- run resets to 1 and a long-press clear keeps it at 1,
//        restarting the divider from 0; undefined, run resets to 0 and clear forces it to 0.
module stopwatch_key_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYC = stopwatch_pkg::DEBOUNCE_CYC,
  parameter int LONG_CYC     = stopwatch_pkg::LONG_CYC,
  parameter int TICK_CYC     = stopwatch_pkg::TICK_CYC
) (
  input  logic CLOCK_50,
  input  logic KEY0,
  input  logic KEY1,
  output logic run,
  output logic tick,
  output logic clear,
  output logic key_pulse
);

  localparam int DW = cnt_w(DEBOUNCE_CYC);
  localparam int HW = cnt_w(LONG_CYC);
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYC - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYC - 1);

`ifdef STOPWATCH_AUTOSTART_EN
  localparam logic RUN_RST = 1'b1;
`else
  localparam logic RUN_RST = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // KEY1 synchronizer. Flops reset to 1 (key released) so a key held through
  // reset is seen as a fresh falling edge and has to debounce again.
  // ---------------------------------------------------------------------------
  logic ks_meta;
  logic ks;

  always_ff @(posedge CLOCK_50) begin
    if (!KEY0) begin
      ks_meta <= 1'b1;
      ks      <= 1'b1;
    end else begin
      ks_meta <= KEY1;
      ks      <= ks_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Press classification FSM. One debounce counter serves both the press and
  // the release debounce since the two phases never overlap.
  // ---------------------------------------------------------------------------
  key_state_t    state;
  key_state_t    state_nxt;
  logic [DW-1:0] deb_cnt;
  logic [DW-1:0] deb_cnt_nxt;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_cnt_nxt;
  logic          short_flag;
  logic          short_flag_nxt;
  logic          clear_nxt;
  logic          key_pulse_nxt;
  logic          run_nxt;

  // Counters stop at their terminal value because reaching it always moves
  // the FSM out of the counting state, so no explicit saturation is needed.
  always_comb begin
    state_nxt      = state;
    deb_cnt_nxt    = deb_cnt;
    hold_cnt_nxt   = hold_cnt;
    short_flag_nxt = short_flag;
    clear_nxt      = 1'b0;
    key_pulse_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (!ks) begin
          state_nxt   = DEB_PRESS;
          deb_cnt_nxt = '0;
        end
      end

      DEB_PRESS: begin
        if (ks) begin
          // Level went back high before it was stable: treat as bounce.
          state_nxt = IDLE;
        end else if (deb_cnt == DEB_MAX) begin
          state_nxt    = HELD;
          hold_cnt_nxt = '0;
        end else begin
          deb_cnt_nxt = deb_cnt + 1'b1;
        end
      end

      HELD: begin
        // A release seen in the same cycle the hold limit is reached still
        // counts as a short press: the key was let go before LONG_CYC elapsed.
        if (ks) begin
          state_nxt      = DEB_REL;
          short_flag_nxt = 1'b1;
          deb_cnt_nxt    = '0;
        end else if (hold_cnt == HOLD_MAX) begin
          state_nxt = LONG;
          clear_nxt = 1'b1;
        end else begin
          hold_cnt_nxt = hold_cnt + 1'b1;
        end
      end

      LONG: begin
        if (ks) begin
          state_nxt      = DEB_REL;
          short_flag_nxt = 1'b0;
          deb_cnt_nxt    = '0;
        end
      end

      DEB_REL: begin
        if (!ks) begin
          // Release bounce: wait for a fresh run of stable-high samples.
          deb_cnt_nxt = '0;
        end else if (deb_cnt == DEB_MAX) begin
          state_nxt     = IDLE;
          key_pulse_nxt = short_flag;
        end else begin
          deb_cnt_nxt = deb_cnt + 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Run state. key_pulse and clear come from different FSM states, so at most
  // one of them can act on run in any cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    run_nxt = run;
    if (key_pulse_nxt) begin
      run_nxt = ~run;
    end
    if (clear_nxt) begin
`ifdef STOPWATCH_AUTOSTART_EN
      run_nxt = 1'b1;
`else
      run_nxt = 1'b0;
`endif
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!KEY0) begin
      state      <= IDLE;
      deb_cnt    <= '0;
      hold_cnt   <= '0;
      short_flag <= 1'b0;
      run        <= RUN_RST;
      clear      <= 1'b0;
      key_pulse  <= 1'b0;
    end else begin
      state      <= state_nxt;
      deb_cnt    <= deb_cnt_nxt;
      hold_cnt   <= hold_cnt_nxt;
      short_flag <= short_flag_nxt;
      run        <= run_nxt;
      clear      <= clear_nxt;
      key_pulse  <= key_pulse_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Tick divider. It counts only across cycles where run is high now and stays
  // high next, so:
  //  - the cycle run rises holds the divider at 0 (first tick TICK_CYC later);
  //  - a toggle-off cycle clears it and suppresses a tick due in that cycle.
  // A clear restarts it, which also keeps tick and clear from coinciding.
  // ---------------------------------------------------------------------------
  logic div_en;

  assign div_en = run & run_nxt;

  tick_div #(
    .TICK_CYC (TICK_CYC)
  ) u_tick_div (
    .CLOCK_50 (CLOCK_50),
    .KEY0     (KEY0),
    .en       (div_en),
    .restart  (clear_nxt),
    .tick     (tick)
  );

endmodule

// File: tb/tb_stopwatch_key_ctrl.sv
// tb_stopwatch_key_ctrl: directed stimulus for stopwatch_key_ctrl with an expected-pulse scoreboard.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_stopwatch_key_ctrl;

  localparam int DEB = 4;
  localparam int LNG = 20;
  localparam int TCK = 10;

  // Pulse kinds as {tick, clear, key_pulse}; comparing the whole vector also
  // catches two strobes firing in the same cycle.
  localparam logic [2:0] K_TICK = 3'b100;
  localparam logic [2:0] K_CLR  = 3'b010;
  localparam logic [2:0] K_KP   = 3'b001;

  typedef struct {
    int         at;
    logic [2:0] kind;
  } ev_t;

  logic CLOCK_50 = 1'b0;
  logic KEY0;
  logic KEY1;
  logic run;
  logic tick;
  logic clear;
  logic key_pulse;

  int  cyc    = 0;   // number of rising edges so far
  int  errors = 0;
  int  checks = 0;
  ev_t exp_q[$];

  // Reference run state and next due tick, advanced only by stimulus tasks.
  bit  running   = 1'b0;
  int  next_tick = 0;

  ev_t mon_e;
  int  mon_qs;

  stopwatch_key_ctrl #(
    .DEBOUNCE_CYC (DEB),
    .LONG_CYC     (LNG),
    .TICK_CYC     (TCK)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .KEY0      (KEY0),
    .KEY1      (KEY1),
    .run       (run),
    .tick      (tick),
    .clear     (clear),
    .key_pulse (key_pulse)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Every strobe the DUT emits must match the oldest expected event in both
  // kind and cycle.
  always @(negedge CLOCK_50) begin
    if (tick || clear || key_pulse) begin
      mon_qs = exp_q.size();
      checks++;
      assert (mon_qs !== 0) else begin
        errors++;
        $error("FAIL unexpected_pulse cyc=%0d got=%b expected no pulse", cyc, {tick, clear, key_pulse});
      end
      if (mon_qs != 0) begin
        mon_e = exp_q.pop_front();
        checks++;
        assert ({tick, clear, key_pulse} === mon_e.kind) else begin
          errors++;
          $error("FAIL pulse_kind cyc=%0d got=%b expected=%b", cyc, {tick, clear, key_pulse}, mon_e.kind);
        end
        checks++;
        assert (cyc === mon_e.at) else begin
          errors++;
          $error("FAIL pulse_time kind=%b got cyc=%0d expected cyc=%0d", mon_e.kind, cyc, mon_e.at);
        end
      end
    end
  end

  task automatic push_ev(input int at, input logic [2:0] kind);
    ev_t e;
    e.at   = at;
    e.kind = kind;
    exp_q.push_back(e);
  endtask

  // Queue the ticks due strictly before lim; a tick due in the same cycle as
  // a toggle-off or clear is suppressed, hence the strict bound.
  task automatic ticks_until(input int lim);
    while (running && next_tick < lim) begin
      push_ev(next_tick, K_TICK);
      next_tick += TCK;
    end
  endtask

  // Advance n cycles (negedge to negedge), queuing ticks up to the end point first.
  task automatic step(input int n);
    ticks_until(cyc + n + 1);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic chk(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%b expected=%b", tag, cyc, obs, expv);
    end
  endtask

  task automatic chk_drained(input string tag);
    int qs;
    #1;
    qs = exp_q.size();
    checks++;
    assert (qs === 0) else begin
      errors++;
      $error("FAIL %s cyc=%0d pending_events=%0d expected=0", tag, cyc, qs);
    end
  endtask

  // Key low for len rising edges, starting at the next edge F. Timeline:
  //   IDLE sees the synchronized low at F+2;
  //   debounce reaches HELD at F+2+DEB;
  //   release reaches DEB_REL at F+len+2;
  //   release debounce completes at F+len+2+DEB.
  task automatic short_press(input int len);
    int f;
    int kp;
    f  = cyc + 1;
    kp = f + len + 2 + DEB;
    ticks_until(kp);
    push_ev(kp, K_KP);
    running = !running;
    if (running) next_tick = kp + TCK;
    KEY1 = 1'b0;
    step(len);
    KEY1 = 1'b1;
  endtask

  // Held past HELD entry (F+2+DEB) by LNG cycles: clear at F+2+DEB+LNG.
  task automatic long_press(input int len);
    int f;
    int c;
    f = cyc + 1;
    c = f + 2 + DEB + LNG;
    ticks_until(c);
    push_ev(c, K_CLR);
    running = 1'b0;
    KEY1 = 1'b0;
    step(len);
    KEY1 = 1'b1;
  endtask

  initial begin
    KEY0 = 1'b0;
    KEY1 = 1'b1;

    // Reset held for three edges, then released with the key idle.
    step(3);
    chk("rst_run", run, 1'b0);
    chk("rst_tick", tick, 1'b0);
    chk("rst_clear", clear, 1'b0);
    chk("rst_key_pulse", key_pulse, 1'b0);
    KEY0 = 1'b1;
    step(50);
    chk("idle_run", run, 1'b0);

    // Short press: key_pulse at 75, run rises, ticks at 85/95/105.
    step(7);
    short_press(8);
    step(6);
    chk("pre_toggle_run", run, 1'b0);
    step(2);
    chk("post_toggle_run", run, 1'b1);
    step(30);
    chk_drained("ticks_after_start");

    // Bounce every two cycles while running: no press accepted, ticks keep going.
    for (int i = 0; i < 15; i++) begin
      KEY1 = (i % 2 == 0) ? 1'b0 : 1'b1;
      step(2);
    end
    KEY1 = 1'b1;
    step(14);
    chk("bounce_run", run, 1'b1);
    chk_drained("bounce_events");

    // Long press timed so the clear lands on a due tick (185): clear wins.
    step(8);
    long_press(30);
    chk("long_run", run, 1'b0);
    step(22);
    chk("long_release_run", run, 1'b0);
    chk_drained("long_events");

    // Second press 15 cycles after the first: one tick then stop.
    short_press(8);
    step(7);
    short_press(8);
    chk("second_press_before", run, 1'b1);
    step(8);
    chk("second_press_after", run, 1'b0);
    chk_drained("second_press_events");

    // Third press restarts from 0; fourth toggles off on the due tick at 295.
    step(9);
    short_press(8);
    step(22);
    short_press(8);
    step(12);
    chk("fourth_press_run", run, 1'b0);
    chk_drained("toggle_on_tick_events");

    // Reset while in HELD with the counter running.
    short_press(8);
    step(12);
    KEY1 = 1'b0;
    step(10);
    KEY0    = 1'b0;
    running = 1'b0;
    step(1);
    chk("midrst_run", run, 1'b0);
    chk("midrst_tick", tick, 1'b0);
    chk("midrst_clear", clear, 1'b0);
    chk("midrst_key_pulse", key_pulse, 1'b0);
    KEY0 = 1'b1;
    // Key still low: first post-reset sample at 332, released with first high
    // sample at 341, so key_pulse at 332 + 9 + 2 + DEB = 347.
    push_ev(347, K_KP);
    running   = 1'b1;
    next_tick = 347 + TCK;
    step(9);
    KEY1 = 1'b1;
    step(30);
    chk("midrst_rerun", run, 1'b1);
    chk_drained("midrst_events");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
